// File: rtl/decode_issue_sequencer.sv
// Instruction buffer between fetch and decode: FIFO of {instr, pc} with a
// flush/reset recovery window that blocks fetch for FLUSH_CYCLES cycles.
module decode_issue_sequencer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PC_W         = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [PC_W-1:0]          out_pc,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              stall_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned RcW  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StFlush = 1'b1;

  localparam logic [RcW-1:0] RcInit  = RcW'(FLUSH_CYCLES);
  localparam logic [PtrW:0]  CntFull = (PtrW + 1)'(DEPTH);

  logic [0:0]      state_q, state_d;
  logic [RcW-1:0]  rc_q, rc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [15:0]     stall_q, stall_d;

  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];

  logic push, pop;

  always_comb begin
    in_ready  = (state_q == StRun) && (count_q != CntFull);
    out_valid = (count_q != '0);
    out_instr = out_valid ? mem_instr[rd_ptr_q] : '0;
    out_pc    = out_valid ? mem_pc[rd_ptr_q]    : '0;
    count     = count_q;
    stall_cnt = stall_q;
  end

  // Flush discards any handshake that happens in the same cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    state_d  = state_q;
    rc_d     = rc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      state_d  = StFlush;
      rc_d     = RcInit;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (state_q == StFlush) begin
        rc_d = rc_q - 1'b1;
        if (rc_q == RcW'(1)) state_d = StRun;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && !flush && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StFlush;
      rc_q     <= RcInit;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      rc_q     <= rc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Storage needs no reset: reads are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= in_instr;
      mem_pc[wr_ptr_q]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_decode_issue_sequencer.sv
// Bench for decode_issue_sequencer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_decode_issue_sequencer;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned PC_W         = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic [31:0]            in_instr = '0;
  logic [PC_W-1:0]        in_pc = '0;
  logic                   in_ready;
  logic                   out_valid;
  logic [31:0]            out_instr;
  logic [PC_W-1:0]        out_pc;
  logic                   out_ready = 1'b0;
  logic                   flush = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic [15:0]            stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  decode_issue_sequencer #(
    .DEPTH       (DEPTH),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .PC_W        (PC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc   (out_pc),
    .out_ready(out_ready),
    .flush    (flush),
    .count    (count),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of entries, a count of blocked cycles left, and a stall counter.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t m_q[$];
  int   m_blk   = FLUSH_CYCLES;
  int   m_stall = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_blk   = FLUSH_CYCLES;
      m_stall = 0;
    end else begin
      bit rdy, vld;
      rdy = (m_blk == 0) && (m_q.size() < DEPTH);
      vld = (m_q.size() > 0);
      if (flush) begin
        m_q.delete();
        m_blk = FLUSH_CYCLES;
      end else begin
        if (vld && !out_ready && m_stall < 65535) m_stall++;
        if (m_blk > 0) m_blk--;
        if (vld && out_ready) void'(m_q.pop_front());
        if (rdy && in_valid) m_q.push_back('{instr: in_instr, pc: in_pc});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      bit          e_rdy;
      logic [31:0] e_instr, e_pc;
      e_rdy   = (m_blk == 0) && (m_q.size() < DEPTH);
      e_instr = (m_q.size() > 0) ? m_q[0].instr : 32'h0;
      e_pc    = (m_q.size() > 0) ? m_q[0].pc : 32'h0;
      check("model in_ready", 32'(in_ready), 32'(e_rdy));
      check("model out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      check("model count", 32'(count), 32'(m_q.size()));
      check("model out_instr", out_instr, e_instr);
      check("model out_pc", out_pc, e_pc);
      check("model stall_cnt", 32'(stall_cnt), 32'(m_stall));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    int n;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    n = 0;
    while (!in_ready && n < 20) begin
      cyc();
      n++;
    end
    check("push ready within bound", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset count", 32'(count), 32'd0);
    check("reset stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_instr", out_instr, 32'd0);
    rst = 1'b0;

    // 1: recovery window after reset, then first push
    in_valid = 1'b1;
    in_instr = 32'h0050_0093;
    in_pc    = 32'h0;
    check("t1 ready cyc1", 32'(in_ready), 32'd0);
    cyc();
    check("t1 ready cyc2", 32'(in_ready), 32'd0);
    cyc();
    check("t1 ready cyc3", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    check("t1 out_valid", 32'(out_valid), 32'd1);
    check("t1 out_instr", out_instr, 32'h0050_0093);
    check("t1 out_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("t1 drained", 32'(count), 32'd0);

    // 2: fill to full, fifth held until a pop
    for (int i = 0; i < 4; i++) push(32'hA000_0000 | 32'(i), 32'(4 * i));
    check("t2 count full", 32'(count), 32'd4);
    check("t2 ready full", 32'(in_ready), 32'd0);
    check("t2 head pc", out_pc, 32'd0);
    in_valid = 1'b1;
    in_instr = 32'hA000_0004;
    in_pc    = 32'd16;
    cyc();
    check("t2 fifth held", 32'(count), 32'd4);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("t2 after pop count", 32'(count), 32'd3);
    check("t2 after pop pc", out_pc, 32'd4);
    cyc();
    in_valid = 1'b0;
    check("t2 fifth accepted", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("t2 drain order", out_pc, 32'(4 * k));
      cyc();
    end
    out_ready = 1'b0;
    check("t2 empty", 32'(out_valid), 32'd0);
    check("t2 empty instr", out_instr, 32'd0);

    // 3: simultaneous push/pop at count 2, wraps pointers
    push(32'hB000_0000, 32'd100);
    push(32'hB000_0001, 32'd104);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_instr = 32'hC000_0000 | 32'(j);
      in_pc    = 32'(200 + 4 * j);
      cyc();
      check("t3 count steady", 32'(count), 32'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t3 head pc", out_pc, 32'd232);
    check("t3 head instr", out_instr, 32'hC000_0008);

    // 4: flush at count 3 with both handshakes offered
    push(32'hD000_0000, 32'd300);
    check("t4 count3", 32'(count), 32'd3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc();
    flush     = 1'b0;
    out_ready = 1'b0;
    check("t4 count cleared", 32'(count), 32'd0);
    check("t4 out_valid", 32'(out_valid), 32'd0);
    check("t4 ready f1", 32'(in_ready), 32'd0);
    cyc();
    check("t4 ready f2", 32'(in_ready), 32'd0);
    cyc();
    check("t4 ready run", 32'(in_ready), 32'd1);
    in_valid = 1'b0;

    // 5: second flush on first recovery cycle restarts the window
    flush = 1'b1;
    cyc();
    check("t5 ready first", 32'(in_ready), 32'd0);
    cyc();
    flush = 1'b0;
    check("t5 ready a", 32'(in_ready), 32'd0);
    cyc();
    check("t5 ready b", 32'(in_ready), 32'd0);
    cyc();
    check("t5 ready run", 32'(in_ready), 32'd1);

    // 6: stall counter saturation, survives flush, cleared by reset
    push(32'hE000_0000, 32'd400);
    out_ready = 1'b0;
    repeat (70000) cyc();
    check("t6 stall sat", 32'(stall_cnt), 32'h0000_FFFF);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("t6 stall after flush", 32'(stall_cnt), 32'h0000_FFFF);
    check("t6 count after flush", 32'(count), 32'd0);
    rst = 1'b1;
    #1;
    check("t6 stall reset", 32'(stall_cnt), 32'd0);
    check("t6 out_valid reset", 32'(out_valid), 32'd0);
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
    check("t6 ready after reset", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
